// File: rtl/imem_boot_loader_if.sv
// Host byte link, instruction RAM write port and core status of the boot loader.
// The master side is the host/core; the slave side is the loader.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, busy, done, error, words_loaded
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, busy, done, error, words_loaded
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Serial boot loader: parses a 16-bit word-count header followed by little-endian
// words and writes them into instruction RAM, holding the core until the image is complete.
module imem_boot_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    imem_boot_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [15:0]       n_q;
    logic [1:0]        idx_q;
    logic [31:0]       word_q;
    logic [ADDR_W:0]   words_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              busy_q, done_q, error_q, hold_q;

    logic              rx_ready;
    logic              accept;
    logic              restart;
    logic [15:0]       n_full;
    logic [31:0]       word_nxt;
    logic              last_word;

    assign rx_ready  = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA);
    assign accept    = rx_ready & bus.rx_valid;
    assign restart   = bus.start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
    assign n_full    = {bus.rx_data, n_q[7:0]};
    // Bytes enter at the top and shift down, so the first byte ends in [7:0].
    assign word_nxt  = {bus.rx_data, word_q[31:8]};
    assign last_word = (16'(words_q) + 16'd1) == n_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.start) state_d = HDR0;
            HDR0:  if (accept) state_d = HDR1;
            HDR1: begin
                if (accept) begin
                    if (n_full == 16'd0)                    state_d = DONE;
                    else if ({1'b0, n_full} > 17'(DEPTH))   state_d = ERR;
                    else                                    state_d = DATA;
                end
            end
            DATA:  if (accept && idx_q == 2'd3) state_d = WRITE;
            WRITE: state_d = last_word ? DONE : DATA;
            DONE:  if (bus.start) state_d = HDR0;
            ERR:   if (bus.start) state_d = HDR0;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            idx_q    <= '0;
            word_q   <= '0;
            words_q  <= '0;
            mem_we_q <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            hold_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            busy_q   <= (state_d == HDR0) || (state_d == HDR1) || (state_d == DATA) || (state_d == WRITE);
            done_q   <= (state_d == DONE);
            error_q  <= (state_d == ERR);
            hold_q   <= (state_d != DONE);
            mem_we_q <= (state_d == WRITE);

            if (restart) begin
                words_q <= '0;
                idx_q   <= '0;
            end
            if (accept && state_q == HDR0) n_q[7:0]  <= bus.rx_data;
            if (accept && state_q == HDR1) n_q[15:8] <= bus.rx_data;
            if (accept && state_q == DATA) begin
                word_q <= word_nxt;
                idx_q  <= idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    waddr_q <= words_q[ADDR_W-1:0];
                    wdata_q <= word_nxt;
                end
            end
            if (state_q == WRITE) words_q <= words_q + 1'b1;
        end
    end

    assign bus.rx_ready     = rx_ready;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_waddr    = waddr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.cpu_hold     = hold_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.words_loaded = words_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: a byte-count reference model predicts every
// output each cycle, and loaded images are compared word by word with what was sent.
module tb_imem_boot_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_W(8)) bus ();

    imem_boot_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes consumed in the current load, a pending write, and the outcome.
    bit          m_load, m_wr;
    int          m_cnt, m_n, m_words, m_fin, m_pos;   // m_fin: 0 none, 1 done, 2 error
    logic [7:0]  m_waddr;
    logic [31:0] m_wdata, m_acc;

    logic [31:0] img    [256];
    logic [31:0] shadow [256];
    int          shadow_id [256];
    int          load_id  = 0;
    int          we_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_loop();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_load = 0; m_wr = 0; m_cnt = 0; m_n = 0; m_words = 0; m_fin = 0;
                m_waddr = '0; m_wdata = '0; m_acc = '0;
            end else if (m_wr) begin
                m_wr = 0;
                m_words++;
                if (m_words == m_n) begin m_load = 0; m_fin = 1; end
            end else if (m_load) begin
                if (bus.rx_valid) begin
                    if (m_cnt == 0) m_n = int'(bus.rx_data);
                    else if (m_cnt == 1) begin
                        m_n = m_n + 256 * int'(bus.rx_data);
                        if (m_n == 0)       begin m_load = 0; m_fin = 1; end
                        else if (m_n > 256) begin m_load = 0; m_fin = 2; end
                    end else begin
                        m_pos = (m_cnt - 2) % 4;
                        m_acc[m_pos*8 +: 8] = bus.rx_data;
                        if (m_pos == 3) begin m_wr = 1; m_waddr = 8'(m_words); m_wdata = m_acc; end
                    end
                    m_cnt++;
                end
            end else if (bus.start) begin
                m_load = 1; m_cnt = 0; m_words = 0; m_fin = 0;
            end
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("rx_ready",     32'(bus.rx_ready),     32'(m_load && !m_wr));
            chk("busy",         32'(bus.busy),         32'(m_load));
            chk("mem_we",       32'(bus.mem_we),       32'(m_wr));
            chk("done",         32'(bus.done),         32'(m_fin == 1));
            chk("error",        32'(bus.error),        32'(m_fin == 2));
            chk("cpu_hold",     32'(bus.cpu_hold),     32'(m_fin != 1));
            chk("words_loaded", 32'(bus.words_loaded), 32'(m_words));
            chk("mem_waddr",    32'(bus.mem_waddr),    32'(m_waddr));
            chk("mem_wdata",    bus.mem_wdata,         m_wdata);
            if (bus.mem_we === 1'b1) begin
                chk("ready_in_write", 32'(bus.rx_ready), 32'd0);
                shadow[bus.mem_waddr]    = bus.mem_wdata;
                shadow_id[bus.mem_waddr] = load_id;
                we_total++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        bit r = 0;
        bus.rx_data = b; bus.rx_valid = 1'b1;
        for (int i = 0; i < 200 && !r; i++) begin
            @(negedge clk); r = bus.rx_ready; tick();
        end
        bus.rx_valid = 1'b0;
        if (!r) chk("rx_accept_timeout", 32'd0, 32'd1);
        repeat ($urandom_range(0, gapmax)) begin bus.rx_data = 8'($urandom); tick(); end
    endtask

    task automatic send_data(input int lo, input int hi, input int gapmax);
        for (int i = lo; i < hi; i++) send_byte(img[i/4][8*(i%4) +: 8], gapmax);
    endtask

    task automatic wait_end();
        bit f = 0;
        for (int i = 0; i < 64 && !f; i++) begin
            @(negedge clk); f = bus.done || bus.error;
            if (!f) tick();
        end
        if (!f) chk("end_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_img(input int n, input int base);
        chk("we_count", 32'(we_total - base), 32'(n));
        for (int k = 0; k < n; k++) begin
            chk("img_written", 32'(shadow_id[k]), 32'(load_id));
            chk("img_data", shadow[k], img[k]);
        end
    endtask

    task automatic load(input int n, input int gapmax);
        int base;
        load_id++; base = we_total;
        for (int k = 0; k < 256; k++) img[k] = $urandom;
        pulse_start();
        send_byte(8'(n), gapmax);
        send_byte(8'(n >> 8), gapmax);
        if (n >= 1 && n <= 256) send_data(0, 4*n, gapmax);
        wait_end();
        chk("load_done",  32'(bus.done),  32'(n <= 256));
        chk("load_error", 32'(bus.error), 32'(n > 256));
        chk("load_words", 32'(bus.words_loaded), (n <= 256) ? 32'(n) : 32'd0);
        if (n <= 256) check_img(n, base);
        else chk("err_no_writes", 32'(we_total - base), 32'd0);
        tick();
    endtask

    initial begin
        logic [7:0] t1 [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        int base, n;
        rst = 1'b1; bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
        fork
            model_loop();
            compare_loop();
        join_none
        repeat (3) tick();
        @(negedge clk);
        chk("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("rst_words",    32'(bus.words_loaded), 32'd0);
        tick(); rst = 1'b0; tick();

        // Two-word image with known contents.
        load_id++; base = we_total;
        pulse_start();
        foreach (t1[i]) send_byte(t1[i], 0);
        wait_end();
        chk("t1_word0", shadow[0], 32'h0000_0013);
        chk("t1_word1", shadow[1], 32'h0010_0093);
        chk("t1_model_wdata", m_wdata, 32'h0010_0093);
        chk("t1_we_count", 32'(we_total - base), 32'd2);
        chk("t1_words", 32'(bus.words_loaded), 32'd2);
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_hold", 32'(bus.cpu_hold), 32'd0);
        tick();

        // Empty image, started from DONE.
        base = we_total;
        pulse_start();
        @(negedge clk);
        chk("t2_hold_after_start", 32'(bus.cpu_hold), 32'd1);
        chk("t2_busy", 32'(bus.busy), 32'd1);
        tick();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        @(negedge clk);
        chk("t2_done", 32'(bus.done), 32'd1);
        chk("t2_words", 32'(bus.words_loaded), 32'd0);
        chk("t2_no_we", 32'(we_total - base), 32'd0);
        tick();

        // Oversized header.
        base = we_total;
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h01, 0);
        bus.rx_valid = 1'b1; tick(); tick(); bus.rx_valid = 1'b0;
        @(negedge clk);
        chk("t3_error", 32'(bus.error), 32'd1);
        chk("t3_ready", 32'(bus.rx_ready), 32'd0);
        chk("t3_hold",  32'(bus.cpu_hold), 32'd1);
        chk("t3_no_we", 32'(we_total - base), 32'd0);
        tick();

        // Full-depth image with random gaps.
        load(256, 3);
        chk("t4_words_256", 32'(bus.words_loaded), 32'd256);

        // Reset in the middle of a load, then a clean reload.
        for (int k = 0; k < 256; k++) img[k] = $urandom;
        pulse_start();
        send_byte(8'h03, 1); send_byte(8'h00, 1);
        send_data(0, 6, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_hold", 32'(bus.cpu_hold), 32'd1);
        chk("t5_done", 32'(bus.done), 32'd0);
        chk("t5_words", 32'(bus.words_loaded), 32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        tick(); rst = 1'b0; tick();
        load(5, 2);

        // start mid-load is ignored; start in DONE restarts.
        load_id++; base = we_total;
        for (int k = 0; k < 256; k++) img[k] = $urandom;
        pulse_start();
        send_byte(8'h04, 0); send_byte(8'h00, 0);
        send_data(0, 6, 1);
        pulse_start();
        send_data(6, 16, 1);
        wait_end();
        chk("t6_done", 32'(bus.done), 32'd1);
        chk("t6_words", 32'(bus.words_loaded), 32'd4);
        check_img(4, base);
        tick();
        pulse_start();
        @(negedge clk);
        chk("t6_restart_hold", 32'(bus.cpu_hold), 32'd1);
        tick();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        wait_end();
        tick();

        // Random mix of sizes, including empty and oversized headers.
        for (int r = 0; r < 8; r++) begin
            case ($urandom_range(0, 4))
                0:       n = $urandom_range(257, 3000);
                1:       n = 0;
                default: n = $urandom_range(1, 24);
            endcase
            load(n, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
